// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit scheduler:
//     - N_REQ_DEFAULT : default number of requesters sharing the transmitter
//     - ST_*          : FSM state encodings, wrapped by the state_t enum
//     - wrap_add      : modulo-n addition used for round-robin rotation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

    localparam int N_REQ_DEFAULT = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SEND  = ST_SEND,
        DRAIN = ST_DRAIN,
        GAP   = ST_GAP
    } state_t;

    // (a + b) mod n, valid when both operands are already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Returns the first set request bit at
//   or after ptr, wrapping modulo N.
//   Ports:
//     req   in  N      request vector
//     ptr   in  IDX_W  index with highest priority this round
//     grant out N      one-hot selected requester (zero if no request)
//     idx   out IDX_W  binary index of the selected requester
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rr_pick
    import uart_pkg::*;
#(
    parameter int N     = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down to ptr itself, so the candidate
    // closest to ptr overwrites any earlier hit and no early exit is needed.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_add(int'(ptr), i, N)]) begin
                grant = '0;
                grant[wrap_add(int'(ptr), i, N)] = 1'b1;
                idx   = IDX_W'(wrap_add(int'(ptr), i, N));
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Packet-atomic round-robin scheduler feeding N_REQ byte streams into one
//   UART transmitter, with a programmable idle gap after each packet.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     req_valid_i  in  N_REQ    byte offered, per requester
//     req_data_i   in  8*N_REQ  offered bytes, requester k at [8k+7:8k]
//     req_last_i   in  N_REQ    offered byte ends its packet
//     req_ready_o  out N_REQ    capture strobe, granted requester only
//     tx_data_o    out 8        byte presented to the transmitter
//     tx_valid_o   out 1        transmit request
//     tx_ready_i   in  1        transmitter idle; falls when a byte is taken
//     gap_i        in  GAP_W    idle cycles inserted after each packet
//     grant_o      out N_REQ    one-hot owner of the transmitter, else zero
//     busy_o       out 1        high in every state except IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int GAP_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [GAP_W-1:0]     gap_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gidx_q,   gidx_d;
    logic [N_REQ-1:0]   grant_q,  grant_d;
    logic [7:0]         data_q,   data_d;
    logic               last_q,   last_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;

    logic [N_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        data_d      = data_q;
        last_d      = last_q;
        gap_d       = gap_q;
        req_ready_o = '0;

        case (state_q)
            IDLE: begin
                // Arbitration happens only here; the grant then sticks for
                // the whole packet regardless of the other request lines.
                if (|req_valid_i) begin
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                // A stalled requester keeps the lock; we simply wait here.
                if (req_valid_i[gidx_q]) begin
                    data_d  = req_data_i[8*gidx_q +: 8];
                    last_d  = req_last_i[gidx_q];
                    // Gated by rst_n so a reset edge can never complete a
                    // handshake for an abandoned packet.
                    req_ready_o = rst_n ? grant_q : '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                // The transmitter signals acceptance by dropping ready.
                if (!tx_ready_i) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (tx_ready_i) begin
                    if (!last_q) begin
                        state_d = LOAD;
                    end else begin
                        grant_d  = '0;
                        rr_ptr_d = IDX_W'(wrap_add(int'(gidx_q), 1, N_REQ));
                        if (gap_i != '0) begin
                            gap_d   = gap_i;
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            GAP: begin
                // Loaded on entry, so a GAP of n lasts exactly n cycles.
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the reset clears the captured byte and gap counter too,
            // not just control state, so tx_data_o is 0x00 after reset.
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
        end
    end

    assign tx_valid_o = (state_q == SEND);
    assign tx_data_o  = data_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of byte-stream requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_W, default 16, SHALL set the width of the inter-packet gap counter.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous and active-low.
REQ-005 req_valid_i  in  N_REQ  SHALL flag, per requester, that a byte is offered.
REQ-006 req_data_i  in  8*N_REQ  SHALL carry the offered bytes; requester k uses bits [8k+7:8k].
REQ-007 req_last_i  in  N_REQ  SHALL mark the offered byte as the last byte of its packet.
REQ-008 req_ready_o  out  N_REQ  SHALL pulse one cycle, on the granted bit only, when that requester's byte is captured.
REQ-009 tx_data_o  out  8  SHALL carry the byte presented to the transmitter.
REQ-010 tx_valid_o  out  1  SHALL request transmission of tx_data_o.
REQ-011 tx_ready_i  in  1  SHALL be the transmitter ready; it is high when idle and falls when a byte is accepted.
REQ-012 gap_i  in  GAP_W  SHALL set the number of idle clk cycles inserted after each packet.
REQ-013 grant_o  out  N_REQ  SHALL be one-hot for the requester currently holding the transmitter, else zero.
REQ-014 busy_o  out  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have five states: IDLE, LOAD, SEND, DRAIN and GAP.
REQ-016 IDLE: if any req_valid_i bit is set, the block SHALL grant the first set bit at or after rr_ptr, wrapping modulo N_REQ, and go to LOAD the next cycle; otherwise it stays in IDLE.
REQ-017 LOAD: if req_valid_i[g] is set, the block SHALL capture data and last, pulse req_ready_o[g], and go to SEND; otherwise it SHALL hold in LOAD, keeping the packet lock.
REQ-018 SEND: tx_valid_o SHALL be 1 with tx_data_o stable; when tx_ready_i is sampled 0, the block SHALL go to DRAIN.
REQ-019 DRAIN: tx_valid_o SHALL be 0; when tx_ready_i is sampled 1, the next state SHALL be:
- LOAD if the captured byte was not last;
- GAP if it was last and gap_i is nonzero;
- IDLE if it was last and gap_i is zero.
REQ-020 On the last-byte DRAIN exit, the block SHALL clear grant_o and set rr_ptr to (g+1) mod N_REQ.
REQ-021 GAP: the block SHALL load gap_i on entry, decrement the counter each cycle, and go to IDLE when it reaches 0; gap_i changes during GAP SHALL be ignored.
REQ-022 Grant SHALL be packet-atomic; other requesters are never serviced mid-packet.
REQ-023 Requests arriving during SEND, DRAIN or GAP SHALL wait; arbitration happens only in IDLE.
REQ-024 Multiple simultaneous requests in IDLE SHALL be resolved purely by the rr_ptr rotation, with no fixed priority.
REQ-025 Pipeline timing:
- tx_valid_o asserts the cycle after capture.
- At most one byte is outstanding.
- No byte is ever presented while tx_ready_i is low from a prior byte.
REQ-026 Deasserting req_valid_i[g] between bytes of a packet SHALL NOT release the grant.

Reset
REQ-027 While rst_n is 0 at a clock edge, the block SHALL set:
- state IDLE, rr_ptr 0, grant_o 0;
- req_ready_o 0, tx_valid_o 0, tx_data_o 0x00;
- busy_o 0, gap counter 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately; no further req_ready_o pulses occur for it.

Structure
REQ-029 The state encoding localparams and the default N_REQ SHALL live in the shared package uart_pkg.
REQ-030 The round-robin selector SHALL be the sub-module rr_pick (inputs: request vector, pointer; output: one-hot grant and index); it is combinational.

Verification
REQ-031 Single packet: requester 1 sends 0x41, 0x42 (last) with gap_i=3 against a uart_tx model → tx sees 0x41 then 0x42, busy_o stays high for 3 cycles after the final DRAIN, grant_o=0b0010 throughout.
REQ-032 Contention: requesters 0 and 2 both offer 3-byte packets in IDLE with rr_ptr=0 → packet 0 is sent fully before packet 2, with no byte interleave; rr_ptr=3 at the end.
REQ-033 Fairness: all four requesters continuously offer 1-byte packets → grant order is 0,1,2,3,0 with no starvation.
REQ-034 Stall mid-packet: requester 3 drops req_valid_i for 50 cycles after byte 1 of 3 → the block stays in LOAD with grant_o=0b1000; other requests are ignored; the packet resumes.
REQ-035 Reset in SEND: rst_n=0 for one edge while tx_valid_o=1 → the next cycle shows IDLE, tx_valid_o=0, grant_o=0.
REQ-036 Zero gap: last byte with gap_i=0 → the block returns to IDLE on the DRAIN exit with no GAP state.
